alu_exec_unit: RTL and testbench

Parametrised, registered ALU execution unit for the MIPS datapath. It decodes `aluop`/`funct` itself, so no separate ALU control block is needed. Single-cycle ops complete in one clock. MULT/MULTU/DIV/DIVU run iteratively into HI/LO under a valid/ready handshake, and the unit stalls the pipeline through `in_ready`.

---
 rtl/alu_exec_unit_if.sv | 42 ++++
 rtl/alu_exec_unit.sv | 294 +++++++++++++++++++++++++++++
 tb/tb_alu_exec_unit.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_exec_unit_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : alu_exec_unit_if                                              |
// | Purpose  : Request/response bundle between the pipeline and the ALU      |
// |            execution unit (operands, decode fields, result, flags,       |
// |            HI/LO and stall status).                                      |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
interface alu_exec_unit_if #(
  parameter int WIDTH = 32
);
  logic             valid_in;
  logic             in_ready;
  logic [1:0]       aluop;
  logic [5:0]       funct;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;
  logic             illegal;
  logic             div_zero;
  logic             valid_out;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;

  // Pipeline side: issues requests, observes results
  modport master (
    output valid_in, aluop, funct, a, b,
    input  in_ready, result, zero, overflow, illegal, div_zero, valid_out,
           hi, lo, busy
  );

  // Execution unit side
  modport slave (
    input  valid_in, aluop, funct, a, b,
    output in_ready, result, zero, overflow, illegal, div_zero, valid_out,
           hi, lo, busy
  );
endinterface
`default_nettype wire

// File: rtl/alu_exec_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : alu_exec_unit                                                 |
// | Purpose  : Registered MIPS ALU with built-in aluop/funct decode.         |
// |            Single-cycle arithmetic/logic ops, iterative mult/div into    |
// |            HI/LO with in_ready back-pressure.                            |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst,
  alu_exec_unit_if.slave bus
);

  localparam int             CW     = $clog2(WIDTH);
  localparam logic [CW-1:0]  C_LAST = CW'(WIDTH - 1);

  localparam logic [5:0] C_F_ADD   = 6'b100000;
  localparam logic [5:0] C_F_SUB   = 6'b100010;
  localparam logic [5:0] C_F_AND   = 6'b100100;
  localparam logic [5:0] C_F_OR    = 6'b100101;
  localparam logic [5:0] C_F_XOR   = 6'b100110;
  localparam logic [5:0] C_F_NOR   = 6'b100111;
  localparam logic [5:0] C_F_SLT   = 6'b101010;
  localparam logic [5:0] C_F_SLTU  = 6'b101011;
  localparam logic [5:0] C_F_MFHI  = 6'b010000;
  localparam logic [5:0] C_F_MFLO  = 6'b010010;
  localparam logic [5:0] C_F_MULT  = 6'b011000;
  localparam logic [5:0] C_F_MULTU = 6'b011001;
  localparam logic [5:0] C_F_DIV   = 6'b011010;
  localparam logic [5:0] C_F_DIVU  = 6'b011011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  // Mul: {partial product upper, multiplier/low product}. Div: {remainder, quotient}.
  logic [2*WIDTH-1:0]     work_q, work_d;
  // Multiplicand magnitude for mul, divisor magnitude for div
  logic [WIDTH-1:0]       mcand_q, mcand_d;
  logic                   sgn_q, sgn_d;
  logic                   neg_a_q, neg_a_d;
  logic                   neg_b_q, neg_b_d;
  logic                   is_div_q, is_div_d;
  logic                   divz_q, divz_d;
  logic [WIDTH-1:0]       result_q, result_d;
  logic                   zero_q, zero_d;
  logic                   ovf_q, ovf_d;
  logic                   ill_q, ill_d;
  logic                   dz_q, dz_d;
  logic                   vout_q, vout_d;
  logic [WIDTH-1:0]       hi_q, hi_d;
  logic [WIDTH-1:0]       lo_q, lo_d;

  // Single-cycle datapath
  logic [WIDTH-1:0]       w_sum, w_diff, w_res;
  logic                   w_add_ovf, w_sub_ovf;
  logic                   w_ovf, w_ill, w_mul, w_div, w_sgn;
  logic [WIDTH-1:0]       w_mag_a, w_mag_b;

  // Iteration datapath
  logic [WIDTH-1:0]       w_addend;
  logic [WIDTH:0]         w_madd;
  logic [2*WIDTH-1:0]     w_mul_next;
  logic [WIDTH:0]         w_shift, w_trial;
  logic [2*WIDTH-1:0]     w_div_next;

  // Completion datapath
  logic [2*WIDTH-1:0]     w_prod;
  logic [WIDTH-1:0]       w_quo, w_rem;
  logic [WIDTH-1:0]       w_fix_hi, w_fix_lo;

  assign w_sum     = bus.a + bus.b;
  assign w_diff    = bus.a - bus.b;
  assign w_add_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (w_sum[WIDTH-1]  != bus.a[WIDTH-1]);
  assign w_sub_ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (w_diff[WIDTH-1] != bus.a[WIDTH-1]);

  // Signed mul/div run on magnitudes; the most-negative value maps onto 2^(WIDTH-1) unsigned
  assign w_mag_a = (w_sgn && bus.a[WIDTH-1]) ? (~bus.a + 1'b1) : bus.a;
  assign w_mag_b = (w_sgn && bus.b[WIDTH-1]) ? (~bus.b + 1'b1) : bus.b;

  // Decode aluop/funct into a single-cycle result or a multi-cycle launch
  always_comb begin
    w_res = '0;
    w_ovf = 1'b0;
    w_ill = 1'b0;
    w_mul = 1'b0;
    w_div = 1'b0;
    w_sgn = 1'b0;
    case (bus.aluop)
      2'b00: begin
        w_res = w_sum;
        w_ovf = w_add_ovf;
      end
      2'b01: begin
        w_res = w_diff;
        w_ovf = w_sub_ovf;
      end
      2'b10: begin
        case (bus.funct)
          C_F_ADD:   begin w_res = w_sum;  w_ovf = w_add_ovf; end
          C_F_SUB:   begin w_res = w_diff; w_ovf = w_sub_ovf; end
          C_F_AND:   w_res = bus.a & bus.b;
          C_F_OR:    w_res = bus.a | bus.b;
          C_F_XOR:   w_res = bus.a ^ bus.b;
          C_F_NOR:   w_res = ~(bus.a | bus.b);
          C_F_SLT:   w_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
          C_F_SLTU:  w_res = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
          C_F_MFHI:  w_res = hi_q;
          C_F_MFLO:  w_res = lo_q;
          C_F_MULT:  begin w_mul = 1'b1; w_sgn = 1'b1; end
          C_F_MULTU: w_mul = 1'b1;
          C_F_DIV:   begin w_div = 1'b1; w_sgn = 1'b1; end
          C_F_DIVU:  w_div = 1'b1;
          default:   w_ill = 1'b1;
        endcase
      end
      default: w_ill = 1'b1;
    endcase
  end

  // Shift-add step: conditionally add multiplicand to the upper half, then shift right
  assign w_addend   = work_q[0] ? mcand_q : '0;
  assign w_madd     = {1'b0, work_q[2*WIDTH-1:WIDTH]} + {1'b0, w_addend};
  assign w_mul_next = {w_madd, work_q[WIDTH-1:1]};

  // Restoring step: shift in next dividend bit, keep the difference if no borrow
  assign w_shift    = work_q[2*WIDTH-1:WIDTH-1];
  assign w_trial    = w_shift - {1'b0, mcand_q};
  assign w_div_next = w_trial[WIDTH]
                    ? {w_shift[WIDTH-1:0], work_q[WIDTH-2:0], 1'b0}
                    : {w_trial[WIDTH-1:0], work_q[WIDTH-2:0], 1'b1};

  // Sign correction and HI/LO selection for the completing mul/div
  always_comb begin
    w_prod   = work_q;
    w_quo    = work_q[WIDTH-1:0];
    w_rem    = work_q[2*WIDTH-1:WIDTH];
    w_fix_hi = work_q[2*WIDTH-1:WIDTH];
    w_fix_lo = work_q[WIDTH-1:0];
    if (divz_q) begin
      // Divide-by-zero launch preloaded {a, all ones}
      w_fix_hi = work_q[2*WIDTH-1:WIDTH];
      w_fix_lo = work_q[WIDTH-1:0];
    end else if (is_div_q) begin
      if (sgn_q && (neg_a_q ^ neg_b_q)) w_quo = ~work_q[WIDTH-1:0] + 1'b1;
      if (sgn_q && neg_a_q)             w_rem = ~work_q[2*WIDTH-1:WIDTH] + 1'b1;
      w_fix_hi = w_rem;
      w_fix_lo = w_quo;
    end else begin
      if (sgn_q && (neg_a_q ^ neg_b_q)) w_prod = ~work_q + 1'b1;
      w_fix_hi = w_prod[2*WIDTH-1:WIDTH];
      w_fix_lo = w_prod[WIDTH-1:0];
    end
  end

  // Next-state and output update for the IDLE/MUL/DIV/FIX sequencer
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    work_d   = work_q;
    mcand_d  = mcand_q;
    sgn_d    = sgn_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    is_div_d = is_div_q;
    divz_d   = divz_q;
    result_d = result_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    ill_d    = ill_q;
    dz_d     = dz_q;
    vout_d   = 1'b0;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      S_IDLE: begin
        if (bus.valid_in) begin
          if (w_mul || w_div) begin
            cnt_d    = '0;
            sgn_d    = w_sgn;
            neg_a_d  = bus.a[WIDTH-1];
            neg_b_d  = bus.b[WIDTH-1];
            is_div_d = w_div;
            divz_d   = 1'b0;
            if (w_mul) begin
              state_d = S_MUL;
              work_d  = {{WIDTH{1'b0}}, w_mag_b};
              mcand_d = w_mag_a;
            end else if (bus.b == '0) begin
              state_d = S_FIX;
              divz_d  = 1'b1;
              work_d  = {bus.a, {WIDTH{1'b1}}};
            end else begin
              state_d = S_DIV;
              work_d  = {{WIDTH{1'b0}}, w_mag_a};
              mcand_d = w_mag_b;
            end
          end else begin
            result_d = w_res;
            zero_d   = (w_res == '0);
            ovf_d    = w_ovf;
            ill_d    = w_ill;
            dz_d     = 1'b0;
            vout_d   = 1'b1;
          end
        end
      end
      S_MUL: begin
        work_d = w_mul_next;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == C_LAST) state_d = S_FIX;
      end
      S_DIV: begin
        work_d = w_div_next;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == C_LAST) state_d = S_FIX;
      end
      S_FIX: begin
        hi_d     = w_fix_hi;
        lo_d     = w_fix_lo;
        result_d = w_fix_lo;
        zero_d   = (w_fix_lo == '0);
        ovf_d    = 1'b0;
        ill_d    = 1'b0;
        dz_d     = divz_q;
        vout_d   = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset aborts any operation in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      work_q   <= '0;
      mcand_q  <= '0;
      sgn_q    <= 1'b0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      is_div_q <= 1'b0;
      divz_q   <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b1;
      ovf_q    <= 1'b0;
      ill_q    <= 1'b0;
      dz_q     <= 1'b0;
      vout_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      work_q   <= work_d;
      mcand_q  <= mcand_d;
      sgn_q    <= sgn_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      is_div_q <= is_div_d;
      divz_q   <= divz_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      ill_q    <= ill_d;
      dz_q     <= dz_d;
      vout_q   <= vout_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.overflow  = ovf_q;
  assign bus.illegal   = ill_q;
  assign bus.div_zero  = dz_q;
  assign bus.valid_out = vout_q;
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_alu_exec_unit                                              |
// | Purpose  : Directed self-checking bench for alu_exec_unit at WIDTH=32    |
// |            and WIDTH=16.                                                 |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_alu_exec_unit;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  alu_exec_unit_if #(.WIDTH(32)) bus32 ();
  alu_exec_unit_if #(.WIDTH(16)) bus16 ();

  alu_exec_unit #(.WIDTH(32)) u_dut32 (.clk(clk), .rst(rst), .bus(bus32));
  alu_exec_unit #(.WIDTH(16)) u_dut16 (.clk(clk), .rst(rst), .bus(bus16));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [5:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        ovf;
    logic        ill;
  } vec_t;

  vec_t vecs [13];

  // Present one request; returns 1 ns after the accepting edge
  task automatic issue32(input logic [1:0] op, input logic [5:0] fn,
                         input logic [31:0] x, input logic [31:0] y);
    bus32.aluop    = op;
    bus32.funct    = fn;
    bus32.a        = x;
    bus32.b        = y;
    bus32.valid_in = 1'b1;
    @(posedge clk);
    #1;
    bus32.valid_in = 1'b0;
  endtask

  // Count edges until valid_out rises, bounded
  task automatic wait32(output int n);
    n = 0;
    while (bus32.valid_out !== 1'b1 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    n_tests++; if (bus32.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", bus32.in_ready); end
    n_tests++; if (bus32.zero !== 1'b1) begin n_fail++; $display("FAIL reset_zero: got %b expected 1", bus32.zero); end
    n_tests++; if (bus32.hi !== 32'h0) begin n_fail++; $display("FAIL reset_hi: got %h expected 0", bus32.hi); end
    n_tests++; if (bus32.lo !== 32'h0) begin n_fail++; $display("FAIL reset_lo: got %h expected 0", bus32.lo); end
    n_tests++; if (bus32.result !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h expected 0", bus32.result); end
    n_tests++; if (bus32.valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid_out: got %b expected 0", bus32.valid_out); end
    n_tests++; if (bus32.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus32.busy); end
    n_tests++; if ({bus32.overflow, bus32.illegal, bus32.div_zero} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b expected 000", {bus32.overflow, bus32.illegal, bus32.div_zero}); end
    n_tests++; if ({bus16.in_ready, bus16.zero, bus16.hi, bus16.lo} !== {1'b1, 1'b1, 16'h0, 16'h0}) begin n_fail++; $display("FAIL reset_w16: got rdy=%b zero=%b hi=%h lo=%h expected 1 1 0 0", bus16.in_ready, bus16.zero, bus16.hi, bus16.lo); end
  endtask

  // Single-cycle ops, issued back-to-back every cycle
  task automatic test_single_cycle();
    vecs[0]  = '{2'b10, 6'b100000, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b1, 1'b0};
    vecs[1]  = '{2'b01, 6'b000000, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b0, 1'b0};
    vecs[2]  = '{2'b00, 6'b000000, 32'h0000_0010, 32'h0000_0020, 32'h0000_0030, 1'b0, 1'b0};
    vecs[3]  = '{2'b10, 6'b100010, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b0};
    vecs[4]  = '{2'b10, 6'b100100, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1'b0, 1'b0};
    vecs[5]  = '{2'b10, 6'b100101, 32'hF0F0_1234, 32'h0FF0_FF00, 32'hFFF0_FF34, 1'b0, 1'b0};
    vecs[6]  = '{2'b10, 6'b100110, 32'hF0F0_1234, 32'h0FF0_FF00, 32'hFF00_ED34, 1'b0, 1'b0};
    vecs[7]  = '{2'b10, 6'b100111, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h000F_00CB, 1'b0, 1'b0};
    vecs[8]  = '{2'b10, 6'b101010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0};
    vecs[9]  = '{2'b10, 6'b101011, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0};
    vecs[10] = '{2'b10, 6'b111111, 32'h1234_5678, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b1};
    vecs[11] = '{2'b11, 6'b100000, 32'h0000_0003, 32'h0000_0004, 32'h0000_0000, 1'b0, 1'b1};
    vecs[12] = '{2'b10, 6'b100000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0};
    for (int i = 0; i < 13; i++) begin
      issue32(vecs[i].op, vecs[i].fn, vecs[i].a, vecs[i].b);
      n_tests++; if (bus32.result !== vecs[i].res) begin n_fail++; $display("FAIL single[%0d]_result: got %h expected %h", i, bus32.result, vecs[i].res); end
      n_tests++; if (bus32.overflow !== vecs[i].ovf) begin n_fail++; $display("FAIL single[%0d]_overflow: got %b expected %b", i, bus32.overflow, vecs[i].ovf); end
      n_tests++; if (bus32.illegal !== vecs[i].ill) begin n_fail++; $display("FAIL single[%0d]_illegal: got %b expected %b", i, bus32.illegal, vecs[i].ill); end
      n_tests++; if (bus32.zero !== (vecs[i].res == 32'h0)) begin n_fail++; $display("FAIL single[%0d]_zero: got %b expected %b", i, bus32.zero, (vecs[i].res == 32'h0)); end
      n_tests++; if (bus32.valid_out !== 1'b1) begin n_fail++; $display("FAIL single[%0d]_valid_out: got %b expected 1", i, bus32.valid_out); end
    end
    @(posedge clk);
    #1;
    n_tests++; if (bus32.valid_out !== 1'b0) begin n_fail++; $display("FAIL single_pulse_end: got %b expected 0", bus32.valid_out); end
  endtask

  task automatic test_mult();
    int n;
    issue32(2'b10, 6'b011000, 32'hFFFF_FFFD, 32'h0000_0007);
    n_tests++; if ({bus32.busy, bus32.in_ready} !== 2'b10) begin n_fail++; $display("FAIL mult_busy_start: got busy/rdy=%b expected 10", {bus32.busy, bus32.in_ready}); end
    wait32(n);
    n_tests++; if (n !== 33) begin n_fail++; $display("FAIL mult_latency: got %0d expected 33", n); end
    n_tests++; if (bus32.hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mult_hi: got %h expected ffffffff", bus32.hi); end
    n_tests++; if (bus32.lo !== 32'hFFFF_FFEB) begin n_fail++; $display("FAIL mult_lo: got %h expected ffffffeb", bus32.lo); end
    n_tests++; if (bus32.result !== 32'hFFFF_FFEB) begin n_fail++; $display("FAIL mult_result: got %h expected ffffffeb", bus32.result); end
    n_tests++; if ({bus32.busy, bus32.in_ready, bus32.illegal, bus32.overflow} !== 4'b0100) begin n_fail++; $display("FAIL mult_done_status: got %b expected 0100", {bus32.busy, bus32.in_ready, bus32.illegal, bus32.overflow}); end
    // mfhi at the first edge with in_ready high
    issue32(2'b10, 6'b010000, 32'h0, 32'h0);
    n_tests++; if (bus32.result !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mfhi_result: got %h expected ffffffff", bus32.result); end
    issue32(2'b10, 6'b010010, 32'h0, 32'h0);
    n_tests++; if (bus32.result !== 32'hFFFF_FFEB) begin n_fail++; $display("FAIL mflo_result: got %h expected ffffffeb", bus32.result); end
    issue32(2'b10, 6'b011001, 32'hFFFF_FFFF, 32'h0000_0002);
    wait32(n);
    n_tests++; if ({bus32.hi, bus32.lo} !== 64'h0000_0001_FFFF_FFFE) begin n_fail++; $display("FAIL multu_hilo: got %h_%h expected 00000001_fffffffe", bus32.hi, bus32.lo); end
  endtask

  task automatic test_div();
    int n;
    issue32(2'b10, 6'b011010, 32'hFFFF_FFF9, 32'h0000_0002);
    wait32(n);
    n_tests++; if (n !== 33) begin n_fail++; $display("FAIL div_latency: got %0d expected 33", n); end
    n_tests++; if (bus32.lo !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_m7_2_lo: got %h expected fffffffd", bus32.lo); end
    n_tests++; if (bus32.hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div_m7_2_hi: got %h expected ffffffff", bus32.hi); end
    issue32(2'b10, 6'b011010, 32'h0000_0007, 32'hFFFF_FFFE);
    wait32(n);
    n_tests++; if ({bus32.hi, bus32.lo} !== 64'h0000_0001_FFFF_FFFD) begin n_fail++; $display("FAIL div_7_m2: got %h_%h expected 00000001_fffffffd", bus32.hi, bus32.lo); end
    issue32(2'b10, 6'b011010, 32'h8000_0000, 32'hFFFF_FFFF);
    wait32(n);
    n_tests++; if ({bus32.hi, bus32.lo, bus32.div_zero} !== {64'h0000_0000_8000_0000, 1'b0}) begin n_fail++; $display("FAIL div_minneg: got %h_%h dz=%b expected 00000000_80000000 0", bus32.hi, bus32.lo, bus32.div_zero); end
    issue32(2'b10, 6'b011011, 32'h0000_0064, 32'h0000_0007);
    wait32(n);
    n_tests++; if ({bus32.hi, bus32.lo} !== 64'h0000_0002_0000_000E) begin n_fail++; $display("FAIL divu_100_7: got %h_%h expected 00000002_0000000e", bus32.hi, bus32.lo); end
    issue32(2'b10, 6'b011010, 32'h0000_0009, 32'h0000_0000);
    n_tests++; if (bus32.busy !== 1'b1) begin n_fail++; $display("FAIL divz_busy: got %b expected 1", bus32.busy); end
    wait32(n);
    n_tests++; if (n !== 1) begin n_fail++; $display("FAIL divz_latency: got %0d expected 1", n); end
    n_tests++; if ({bus32.div_zero, bus32.hi, bus32.lo} !== {1'b1, 32'h9, 32'hFFFF_FFFF}) begin n_fail++; $display("FAIL divz_result: got dz=%b hi=%h lo=%h expected 1 00000009 ffffffff", bus32.div_zero, bus32.hi, bus32.lo); end
    n_tests++; if ({bus32.result, bus32.zero, bus32.busy} !== {32'hFFFF_FFFF, 1'b0, 1'b0}) begin n_fail++; $display("FAIL divz_res_zero_busy: got %h %b %b expected ffffffff 0 0", bus32.result, bus32.zero, bus32.busy); end
    @(posedge clk);
    #1;
    n_tests++; if ({bus32.valid_out, bus32.div_zero} !== 2'b01) begin n_fail++; $display("FAIL divz_hold: got vout/dz=%b expected 01", {bus32.valid_out, bus32.div_zero}); end
    issue32(2'b00, 6'b000000, 32'h1, 32'h1);
    n_tests++; if ({bus32.div_zero, bus32.result} !== {1'b0, 32'h2}) begin n_fail++; $display("FAIL divz_clear: got dz=%b res=%h expected 0 00000002", bus32.div_zero, bus32.result); end
  endtask

  task automatic test_busy_reset();
    int pulses;
    issue32(2'b10, 6'b011011, 32'h0000_0064, 32'h0000_0007);
    // An add held on valid_in while busy must be dropped
    bus32.aluop    = 2'b00;
    bus32.a        = 32'h1;
    bus32.b        = 32'h2;
    bus32.valid_in = 1'b1;
    for (int i = 1; i < 10; i++) begin
      @(posedge clk);
      #1;
      n_tests++; if ({bus32.valid_out, bus32.busy, bus32.in_ready} !== 3'b010) begin n_fail++; $display("FAIL busy_ignore[%0d]: got vout/busy/rdy=%b expected 010", i, {bus32.valid_out, bus32.busy, bus32.in_ready}); end
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus32.valid_in = 1'b0;
    n_tests++; if ({bus32.valid_out, bus32.in_ready, bus32.busy} !== 3'b010) begin n_fail++; $display("FAIL rst_abort_status: got vout/rdy/busy=%b expected 010", {bus32.valid_out, bus32.in_ready, bus32.busy}); end
    n_tests++; if ({bus32.hi, bus32.lo, bus32.result, bus32.zero} !== {96'h0, 1'b1}) begin n_fail++; $display("FAIL rst_abort_regs: got hi=%h lo=%h res=%h zero=%b expected 0 0 0 1", bus32.hi, bus32.lo, bus32.result, bus32.zero); end
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus32.valid_out === 1'b1) pulses++;
    end
    n_tests++; if (pulses !== 0) begin n_fail++; $display("FAIL rst_no_late_pulse: got %0d expected 0", pulses); end
    n_tests++; if ({bus32.hi, bus32.lo} !== 64'h0) begin n_fail++; $display("FAIL rst_hilo_stays: got %h_%h expected 0", bus32.hi, bus32.lo); end
  endtask

  task automatic test_width16();
    int n;
    bus16.aluop    = 2'b10;
    bus16.funct    = 6'b111111;
    bus16.a        = 16'h1234;
    bus16.b        = 16'h0001;
    bus16.valid_in = 1'b1;
    @(posedge clk);
    #1;
    bus16.valid_in = 1'b0;
    n_tests++; if ({bus16.illegal, bus16.result, bus16.valid_out} !== {1'b1, 16'h0, 1'b1}) begin n_fail++; $display("FAIL w16_illegal: got ill=%b res=%h vout=%b expected 1 0000 1", bus16.illegal, bus16.result, bus16.valid_out); end
    bus16.funct    = 6'b011001;
    bus16.a        = 16'hFFFF;
    bus16.b        = 16'hFFFF;
    bus16.valid_in = 1'b1;
    @(posedge clk);
    #1;
    bus16.valid_in = 1'b0;
    n = 0;
    while (bus16.valid_out !== 1'b1 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    n_tests++; if (n !== 17) begin n_fail++; $display("FAIL w16_multu_latency: got %0d expected 17", n); end
    n_tests++; if ({bus16.hi, bus16.lo, bus16.result} !== {16'hFFFE, 16'h0001, 16'h0001}) begin n_fail++; $display("FAIL w16_multu: got hi=%h lo=%h res=%h expected fffe 0001 0001", bus16.hi, bus16.lo, bus16.result); end
  endtask

  initial begin
    n_tests        = 0;
    n_fail         = 0;
    rst            = 1'b1;
    bus32.valid_in = 1'b0;
    bus32.aluop    = 2'b00;
    bus32.funct    = 6'b000000;
    bus32.a        = '0;
    bus32.b        = '0;
    bus16.valid_in = 1'b0;
    bus16.aluop    = 2'b00;
    bus16.funct    = 6'b000000;
    bus16.a        = '0;
    bus16.b        = '0;
    test_reset();
    test_single_cycle();
    test_mult();
    test_div();
    test_busy_reset();
    test_width16();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
